// File: rtl/dual_port_ssram_be.sv
// dual_port_ssram_be: true dual-port byte-enable SRAM with collision handling and zero-fill sequencer; DSSRAM_COLLISION_COUNT_EN enables the write/write collision counter
module dual_port_ssram_be #(
  parameter int bitwidth       = 32,
  parameter int nrOfEntries    = 512,
  parameter int readAfterWrite = 0,
  parameter int outputRegister = 0,
  parameter int clearOnReset   = 1,
  localparam int nrBytes = bitwidth / 8,
  localparam int addrW   = nrOfEntries > 1 ? $clog2(nrOfEntries) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  output logic                busy_o,
  input  logic                enableA_i,
  input  logic                writeEnableA_i,
  input  logic [nrBytes-1:0]  byteEnableA_i,
  input  logic [addrW-1:0]    addressA_i,
  input  logic [bitwidth-1:0] dataInA_i,
  output logic [bitwidth-1:0] dataOutA_o,
  output logic                validOutA_o,
  input  logic                enableB_i,
  input  logic                writeEnableB_i,
  input  logic [nrBytes-1:0]  byteEnableB_i,
  input  logic [addrW-1:0]    addressB_i,
  input  logic [bitwidth-1:0] dataInB_i,
  output logic [bitwidth-1:0] dataOutB_o,
  output logic                validOutB_o,
  output logic                collision_o,
  output logic [15:0]         collisionCount_o
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q;
  logic [addrW-1:0] ptr_q;
  logic busy_q;
  logic [bitwidth-1:0] mem_q [nrOfEntries];
  logic acc_a, acc_b, in_a, in_b, same, col_d;
  logic [nrBytes-1:0] m_a, m_b;
  logic [bitwidth-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
  logic v1a_q, v1b_q, c1_q, v2a_q, v2b_q, c2_q;
  logic [bitwidth-1:0] d1a_q, d1b_q, d2a_q, d2b_q;
  // merge both ports' lane writes into one word per address; port A wins shared lanes
  always_comb begin
    acc_a = enableA_i & ~busy_q & ~reset_i;
    acc_b = enableB_i & ~busy_q & ~reset_i;
    in_a  = 32'(addressA_i) < nrOfEntries;
    in_b  = 32'(addressB_i) < nrOfEntries;
    same  = addressA_i == addressB_i;
    old_a = in_a ? mem_q[addressA_i] : '0;
    old_b = in_b ? mem_q[addressB_i] : '0;
    m_a   = (acc_a & writeEnableA_i & in_a) ? byteEnableA_i : '0;
    m_b   = (acc_b & writeEnableB_i & in_b) ? byteEnableB_i : '0;
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < nrBytes; i++) begin
      new_a[8*i +: 8] = m_a[i] ? dataInA_i[8*i +: 8] : (m_b[i] & same) ? dataInB_i[8*i +: 8] : old_a[8*i +: 8];
      new_b[8*i +: 8] = (m_a[i] & same) ? dataInA_i[8*i +: 8] : m_b[i] ? dataInB_i[8*i +: 8] : old_b[8*i +: 8];
    end
    rd_a  = readAfterWrite != 0 ? old_a : new_a;
    rd_b  = readAfterWrite != 0 ? old_b : new_b;
    col_d = acc_a & acc_b & same & (writeEnableA_i | writeEnableB_i);
  end
  // storage: the sweep owns the array while clearing, otherwise the ports write merged words
  always_ff @(posedge clock_i) begin
    if (state_q == CLEAR) mem_q[ptr_q] <= '0;
    else begin
      if (|m_a) mem_q[addressA_i] <= new_a;
      if (|m_b) mem_q[addressB_i] <= new_b;
    end
  end
  // zero-fill sequencer; busy is registered alongside the state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= clearOnReset != 0 ? CLEAR : IDLE;
      ptr_q   <= '0;
      busy_q  <= clearOnReset != 0;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + addrW'(1);
      if (ptr_q == addrW'(nrOfEntries - 1)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end
  // read pipeline; data registers only load on a live access so outputs hold otherwise
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      {v1a_q, v1b_q, c1_q, v2a_q, v2b_q, c2_q} <= '0;
      {d1a_q, d1b_q, d2a_q, d2b_q} <= '0;
    end else begin
      v1a_q <= acc_a;
      v1b_q <= acc_b;
      c1_q  <= col_d;
      v2a_q <= v1a_q;
      v2b_q <= v1b_q;
      c2_q  <= c1_q;
      if (acc_a) d1a_q <= rd_a;
      if (acc_b) d1b_q <= rd_b;
      if (v1a_q) d2a_q <= d1a_q;
      if (v1b_q) d2b_q <= d1b_q;
    end
  end
  assign busy_o      = busy_q;
  assign dataOutA_o  = outputRegister != 0 ? d2a_q : d1a_q;
  assign dataOutB_o  = outputRegister != 0 ? d2b_q : d1b_q;
  assign validOutA_o = outputRegister != 0 ? v2a_q : v1a_q;
  assign validOutB_o = outputRegister != 0 ? v2b_q : v1b_q;
  assign collision_o = outputRegister != 0 ? c2_q : c1_q;
`ifdef DSSRAM_COLLISION_COUNT_EN
  logic ww_d, w1_q, ww_o;
  logic [15:0] cnt_q;
  assign ww_d = col_d & writeEnableA_i & writeEnableB_i;
  assign ww_o = outputRegister != 0 ? w1_q : ww_d;
  // saturating write/write counter, timed to change together with the collision pulse
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      w1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      w1_q <= ww_d;
      if (ww_o && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign collisionCount_o = cnt_q;
`else
  assign collisionCount_o = '0;
`endif
endmodule

// File: doc/dual_port_ssram_be.md
Name: dual_port_ssram_be

Overview:
- Single-clock, true dual-port synchronous SRAM with per-byte write enables, configurable read latency and read-during-write mode.
- Defined cross-port collision handling and a hardware zero-fill sequencer after reset.
- Successor to the basic dual-port RAM; used as shared buffer memory between the processor bus side and DMA engines.

Parameters:
- bitwidth, 32, data word width; must be a multiple of 8; nrBytes = bitwidth/8.
- nrOfEntries, 512, number of words; need not be a power of two; addrW = $clog2(nrOfEntries).
- readAfterWrite, 0, 0 = read returns newly written (merged) word; 1 = read returns old word.
- outputRegister, 0, 1 = extra output pipeline stage; read latency L = 1 + outputRegister.
- clearOnReset, 1, 1 = zero-fill all entries after reset; 0 = contents untouched by reset.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear sequencer runs.
- enableA  in  1  port A access strobe.
- writeEnableA  in  1  port A write qualifier; ignored unless enableA=1.
- byteEnableA  in  nrBytes  port A byte-lane write mask.
- addressA  in  addrW  port A word address.
- dataInA  in  bitwidth  port A write data.
- dataOutA  out  bitwidth  port A read data.
- validOutA  out  1  one-cycle pulse marking dataOutA valid.
- enableB, writeEnableB, byteEnableB, addressB, dataInB, dataOutB, validOutB: identical for port B.
- collision  out  1  pulse: same-address access with at least one write.
- collisionCount  out  16  write/write collision counter (see Optional Feature).

Behaviour:
- Reset (reset=1 at an edge):
  - dataOutA/B=0, validOutA/B=0, collision=0, collisionCount=0.
  - Pipeline stages flushed.
  - Sequencer to CLEAR with pointer 0 if clearOnReset=1, else IDLE.
  - busy=clearOnReset while reset is held.
- Sequencer states:
  - IDLE: busy=0; ports operate normally.
  - CLEAR: busy=1; writes 0 to entry[pointer] each cycle, pointer+1.
  - CLEAR → IDLE after pointer = nrOfEntries-1 is written; busy falls the following cycle. Total nrOfEntries cycles after reset deasserts.
  - Reset during CLEAR restarts at pointer 0.
- While busy=1: enableA/B masked, no writes, validOut stays 0, dataOut holds.
- Access:
  - enableX sampled at edge N; dataOutX updated and validOutX=1 at edge N+L-1 (L=1: visible after edge N; L=2: after edge N+1).
  - validOutX is high for one cycle per access; back-to-back accesses give continuous valid.
  - dataOutX holds its last value when no access is in flight.
- Write: lane i (bits 8i+7:8i) written iff enableX & writeEnableX & byteEnableX[i]. Every access also returns read data.
- Same-port read-during-write: readAfterWrite=0 returns merged new word; =1 returns pre-write word.
- Cross-port, same address, same cycle:
  - Both writing: lanes enabled on one port take that port's data; lanes enabled on both take port A data.
  - One writes, other reads: reader gets the merged new word if readAfterWrite=0, old word if readAfterWrite=1.
  - Both ports always see the identical word for that address.
  - collision pulses at the same cycle as the validOut pulses. Read/read on the same address is not a collision.
- Out-of-range address (≥ nrOfEntries): write dropped, read data 0, validOut still pulses.

Optional Feature:
- Macro: DSSRAM_COLLISION_COUNT_EN.
- Defined: collisionCount increments by 1 on each write/write same-address collision. Saturates at 16'hFFFF, cleared only by reset, updates in the same cycle as the collision pulse.
- Undefined: counter logic absent; collisionCount tied to 0. The collision pulse is unaffected either way.

Test Plan:
- Reset clear: clearOnReset=1, nrOfEntries=512, release reset → busy=1 for exactly 512 cycles; then reading any address returns 0. Access attempted during busy gives no validOut.
- Byte-lane write, bitwidth=32: write 32'hAABBCCDD to addr 5 with be=4'b1111, then 32'h11223344 with be=4'b0101 → read returns 32'hAA22CC44, valid at latency 1 (outputRegister=0) and 2 (outputRegister=1).
- Read-during-write, same port, addr 3 holding 32'h1, write 32'h2 → readAfterWrite=0 returns 32'h2; readAfterWrite=1 returns 32'h1.
- Write/write collision at addr 7: A writes 32'h0000FFFF be=4'b0011, B writes 32'hFFFFFFFF be=4'b1111 → entry = 32'hFFFFFFFF, collision=1. Then A be=4'b1111 32'h0, B be=4'b1111 32'h12345678 → entry 0, collision=1, collisionCount=2 (macro on) or 0 (off).
- Reset mid-clear: assert reset at pointer 100 for 1 cycle → sweep restarts; busy lasts a full nrOfEntries cycles after release.
- Out-of-range, nrOfEntries=600: write addr 700 → no entry changes; read addr 700 → dataOut=0, validOut=1.
